falling_lane_multi: RTL

//  Parametrised successor to the single-block falling lane. Tracks up to NSLOT

---
 rtl/falling_lane_multi.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/falling_lane_multi.sv
// falling_lane_multi: tracks up to NSLOT blocks falling in one lane, spawns
// blocks on request, judges key presses against a hit window and reports
// hit/perfect/miss/overflow pulses plus saturating hit and miss counters.
module falling_lane_multi #(
    parameter int unsigned NSLOT   = 4,
    parameter int unsigned HW      = 10,
    parameter int unsigned TOP     = 120,
    parameter int unsigned BOTTOM  = 720,
    parameter int unsigned SPEED   = 1,
    parameter int unsigned HIT_LO  = 600,
    parameter int unsigned HIT_HI  = 680,
    parameter int unsigned PERF_LO = 630,
    parameter int unsigned PERF_HI = 650
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                pause,
    input  logic                tick,
    input  logic                spawn_req,
    input  logic                key,
    output logic [NSLOT*HW-1:0] block_h,
    output logic [NSLOT-1:0]    active,
    output logic                hit,
    output logic                perfect,
    output logic                miss,
    output logic                overflow,
    output logic [7:0]          hit_cnt,
    output logic [7:0]          miss_cnt
);

    localparam logic [HW-1:0] TOP_H     = HW'(TOP);
    localparam logic [HW-1:0] BOTTOM_H  = HW'(BOTTOM);
    localparam logic [HW-1:0] HIT_LO_H  = HW'(HIT_LO);
    localparam logic [HW-1:0] HIT_HI_H  = HW'(HIT_HI);
    localparam logic [HW-1:0] PERF_LO_H = HW'(PERF_LO);
    localparam logic [HW-1:0] PERF_HI_H = HW'(PERF_HI);
    localparam logic [HW:0]   BOTTOM_X  = (HW+1)'(BOTTOM);
    localparam logic [HW:0]   SPEED_X   = (HW+1)'(SPEED);

    // registered state
    logic [HW-1:0]    h_q [NSLOT];
    logic [NSLOT-1:0] act_q;
    logic             hit_q, perf_q, miss_q, ovf_q;
    logic [7:0]       hit_cnt_q, miss_cnt_q;

    // next-state values
    logic [HW-1:0]    h_d [NSLOT];
    logic [NSLOT-1:0] act_d;
    logic             hit_d, perf_d, miss_d, ovf_d;
    logic [7:0]       hit_cnt_d, miss_cnt_d;

    // working values for the per-cycle judge/move/spawn sequence
    logic [NSLOT-1:0] pick_mask;
    logic             pick_found;
    logic [HW-1:0]    pick_h;
    logic             wrong;
    logic [3:0]       nbot;
    logic [HW:0]      sum;
    logic             free_found;
    logic [8:0]       miss_sum;

    // Judge, move and spawn, all decided on the heights registered at cycle start.
    // The judged slot is excluded from motion so one block never yields hit and miss.
    always_comb begin
        for (int unsigned i = 0; i < NSLOT; i++) begin
            h_d[i] = h_q[i];
        end
        act_d      = act_q;
        hit_d      = 1'b0;
        perf_d     = 1'b0;
        miss_d     = 1'b0;
        ovf_d      = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        pick_mask  = '0;
        pick_found = 1'b0;
        pick_h     = '0;
        wrong      = 1'b0;
        nbot       = '0;
        sum        = '0;
        free_found = 1'b0;
        miss_sum   = '0;

        if (!pause) begin
            if (key) begin
                // strict '>' keeps the lowest index on equal heights
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    if (act_q[i] && h_q[i] >= HIT_LO_H && h_q[i] <= HIT_HI_H &&
                        (!pick_found || h_q[i] > pick_h)) begin
                        pick_found = 1'b1;
                        pick_h     = h_q[i];
                        pick_mask  = '0;
                        pick_mask[i] = 1'b1;
                    end
                end
                if (pick_found) begin
                    for (int unsigned i = 0; i < NSLOT; i++) begin
                        if (pick_mask[i]) begin
                            act_d[i] = 1'b0;
                            h_d[i]   = BOTTOM_H;
                        end
                    end
                    hit_d  = 1'b1;
                    perf_d = (pick_h >= PERF_LO_H) && (pick_h <= PERF_HI_H);
                end else begin
                    wrong = 1'b1;
                end
            end

            if (tick) begin
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    if (act_q[i] && !pick_mask[i]) begin
                        sum = {1'b0, h_q[i]} + SPEED_X;
                        if (sum >= BOTTOM_X) begin
                            act_d[i] = 1'b0;
                            h_d[i]   = BOTTOM_H;
                            nbot     = nbot + 4'd1;
                        end else begin
                            h_d[i] = sum[HW-1:0];
                        end
                    end
                end
            end

            if (spawn_req) begin
                // only slots free at cycle start are eligible
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    if (!act_q[i] && !free_found) begin
                        free_found = 1'b1;
                        act_d[i]   = 1'b1;
                        h_d[i]     = TOP_H;
                    end
                end
                ovf_d = !free_found;
            end

            miss_d = wrong || (nbot != 4'd0);

            if (hit_d && hit_cnt_q != 8'hFF) begin
                hit_cnt_d = hit_cnt_q + 8'd1;
            end

            miss_sum   = {1'b0, miss_cnt_q} + 9'(nbot) + 9'(wrong);
            miss_cnt_d = (miss_sum > 9'd255) ? 8'hFF : miss_sum[7:0];
        end
    end

    // State register: async active-low reset, synchronous restart has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                h_q[i] <= BOTTOM_H;
            end
            act_q      <= '0;
            hit_q      <= 1'b0;
            perf_q     <= 1'b0;
            miss_q     <= 1'b0;
            ovf_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (restart) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                h_q[i] <= BOTTOM_H;
            end
            act_q      <= '0;
            hit_q      <= 1'b0;
            perf_q     <= 1'b0;
            miss_q     <= 1'b0;
            ovf_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                h_q[i] <= h_d[i];
            end
            act_q      <= act_d;
            hit_q      <= hit_d;
            perf_q     <= perf_d;
            miss_q     <= miss_d;
            ovf_q      <= ovf_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_pack
        assign block_h[g*HW +: HW] = h_q[g];
    end

    assign active   = act_q;
    assign hit      = hit_q;
    assign perfect  = perf_q;
    assign miss     = miss_q;
    assign overflow = ovf_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
